// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Memory-side responder for the cache packet protocol. Requests from the cache
// controller are queued in order in a small FIFO and serviced against an
// internal word-addressed memory. Writes commit silently. Each read returns one
// response packet after LATENCY cycles of waiting.
//
// Packet layout (PKT_W = DATA_W+ADDR_W+2):
//   [PKT_W-1] valid, [PKT_W-2] is_write,
//   [ADDR_W+DATA_W-1:ADDR_W] data, [ADDR_W-1:0] addr
//
// Ports:
//   clk_in                     clock, rising edge
//   reset_in                   asynchronous, active-high reset
//   cache_packet_from_cache_in request packet, taken whenever valid=1
//   cache_packet_to_cache_out  registered read response, valid for one cycle
//   busy_out                   FIFO non-empty or FSM not idle
//   overflow_out               sticky flag, set when a request is dropped
module cache_mem_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_AW  = 10,
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned LATENCY = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [DATA_W+ADDR_W+1:0] cache_packet_from_cache_in,
    output logic [DATA_W+ADDR_W+1:0] cache_packet_to_cache_out,
    output logic                     busy_out,
    output logic                     overflow_out
);

    localparam int unsigned PKT_W  = DATA_W + ADDR_W + 2;
    localparam int unsigned ENT_W  = DATA_W + ADDR_W + 1;
    localparam int unsigned FIFO_D = 1 << FIFO_AW;
    localparam int unsigned PTR_W  = FIFO_AW + 1;
    localparam int unsigned MEM_D  = 1 << MEM_AW;
    localparam int unsigned CNT_W  = $clog2(LATENCY) + 1;

    // Queued request: the packet without its valid bit.
    typedef struct packed {
        logic              is_write;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PKT_W-1:0]   resp_q, resp_d;
    logic               ovf_q, ovf_d;

    req_t               fifo_q [FIFO_D];
    logic [DATA_W-1:0]  mem_q  [MEM_D];

    req_t               in_req;
    logic               in_valid;
    req_t               head;
    logic [MEM_AW-1:0]  head_idx;
    logic [PTR_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               mem_we;

    // Request decode and FIFO status.
    always_comb begin
        in_valid   = cache_packet_from_cache_in[PKT_W-1];
        in_req     = req_t'(cache_packet_from_cache_in[ENT_W-1:0]);
        head       = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
        head_idx   = head.addr[MEM_AW+1:2];
        fifo_cnt   = wr_ptr_q - rd_ptr_q;
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == PTR_W'(FIFO_D));
    end

    // Next-state: FSM servicing the FIFO head, plus enqueue and overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = '0;
        pop     = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head.is_write) begin
                        mem_we = 1'b1;
                        pop    = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_d  = {1'b1, 1'b0, mem_q[head_idx], head.addr};
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A full FIFO still accepts when the head leaves on the same edge.
        push     = in_valid && (!fifo_full || pop);
        ovf_d    = ovf_q || (in_valid && fifo_full && !pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // Control state register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            resp_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            resp_q   <= resp_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; pointers alone define validity, so no reset needed.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= in_req;
        end
    end

    // Backing store; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[head_idx] <= head.data;
        end
    end

    assign cache_packet_to_cache_out = resp_q;
    assign overflow_out              = ovf_q;
    // Derived only from registered state, so it tracks queue/FSM occupancy.
    assign busy_out                  = !fifo_empty || (state_q != ST_IDLE);

endmodule
